// File: rtl/md_iter_seq_if.sv
// Bus between the EX stage and the iterative multiply/divide unit.
// Valid/ready: start is a one-cycle request, taken only while busy=0; done pulses once per commit.
interface md_iter_seq_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        hi_we;
    logic        lo_we;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, A, B, hi_we, lo_we,
                    input  busy, done, hi, lo);
    modport slave  (input  start, op, A, B, hi_we, lo_we,
                    output busy, done, hi, lo);
endinterface

// File: rtl/md_iter_seq.sv
// Iterative 32-step multiply/divide unit owning HI/LO; mult/multu/div/divu all
// take 33 cycles from accept to visible result on one shared 33-bit adder.
module md_iter_seq (
    input  logic         clk,
    input  logic         reset,
    md_iter_seq_if.slave bus,
    output logic [1:0]   dbg_state
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_FIX = 2'd2} state_t;

    state_t      state, state_nxt;
    logic [1:0]  op_q;
    logic        neg_q, neg_r, dz_q, done_q;
    logic [31:0] a_q, b_q, p_hi, p_lo, hi_q, lo_q;
    logic [4:0]  cnt;

    logic        is_div, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;
    logic [32:0] rem_sh, alu_x, alu_y, alu;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    // Operand magnitudes: bit 0 of op marks the signed variants
    assign a_neg = bus.op[0] & bus.A[31];
    assign b_neg = bus.op[0] & bus.B[31];
    assign a_abs = a_neg ? (32'd0 - bus.A) : bus.A;
    assign b_abs = b_neg ? (32'd0 - bus.B) : bus.B;

    // Shared adder: multiply adds the multiplicand, divide subtracts the divisor
    assign is_div = op_q[1];
    assign rem_sh = {p_hi, a_q[31]};
    assign alu_x  = is_div ? rem_sh : {1'b0, p_hi};
    assign alu_y  = is_div ? {1'b0, b_q} : (b_q[0] ? {1'b0, a_q} : 33'd0);
    assign alu    = alu_x + (is_div ? ~alu_y : alu_y) + {32'd0, is_div};

    assign prod_fix = neg_q ? (64'd0 - {p_hi, p_lo}) : {p_hi, p_lo};
    assign quo_fix  = neg_q ? (32'd0 - p_lo) : p_lo;
    assign rem_fix  = neg_r ? (32'd0 - p_hi) : p_hi;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (bus.start) state_nxt = S_RUN;
            S_RUN:  if (cnt == 5'd0) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy  = (state != S_IDLE);
        bus.done  = done_q;
        bus.hi    = hi_q;
        bus.lo    = lo_q;
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            op_q   <= 2'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
            a_q    <= 32'd0;
            b_q    <= 32'd0;
            p_hi   <= 32'd0;
            p_lo   <= 32'd0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            cnt    <= 5'd0;
        end else begin
            done_q <= (state == S_FIX);
            case (state)
                S_IDLE: begin
                    if (bus.hi_we) hi_q <= bus.A;
                    if (bus.lo_we) lo_q <= bus.A;
                    if (bus.start) begin
                        op_q  <= bus.op;
                        neg_q <= a_neg ^ b_neg;
                        neg_r <= a_neg;
                        dz_q  <= bus.op[1] & (bus.B == 32'd0);
                        a_q   <= a_abs;
                        b_q   <= b_abs;
                        p_hi  <= 32'd0;
                        p_lo  <= 32'd0;
                        cnt   <= 5'd31;
                    end
                end
                S_RUN: begin
                    if (is_div) begin
                        // Restore by keeping the shifted remainder when the trial went negative
                        p_hi <= alu[32] ? rem_sh[31:0] : alu[31:0];
                        p_lo <= {p_lo[30:0], ~alu[32]};
                        a_q  <= {a_q[30:0], 1'b0};
                    end else begin
                        p_hi <= alu[32:1];
                        p_lo <= {alu[0], p_lo[31:1]};
                        b_q  <= {1'b0, b_q[31:1]};
                    end
                    if (cnt != 5'd0) cnt <= cnt - 5'd1;
                end
                S_FIX: begin
                    if (!is_div) begin
                        hi_q <= prod_fix[63:32];
                        lo_q <= prod_fix[31:0];
                    end else if (!dz_q) begin
                        hi_q <= rem_fix;
                        lo_q <= quo_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/md_iter_seq.md
# md_iter_seq

Iterative multiply/divide sequencer for the EX stage. It holds the architectural HI/LO registers and runs `mult`, `multu`, `div` and `divu` as a 32-step shift-add or restoring-division sequence on one internal 33-bit add/subtract datapath. Results are written to HI/LO when the sequence finishes. While the unit is busy, the pipeline hazard unit stalls any instruction that needs the unit.

## Interface
- Parameters: none. Data width is fixed at 32.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  launch the operation in `op`; sampled only in IDLE.
- `op`  in  2  operation select: 00 multu, 01 mult, 10 divu, 11 div.
- `A`  in  32  multiplicand or dividend (rs).
- `B`  in  32  multiplier or divisor (rt).
- `hi_we`  in  1  `mthi` write of `A` into HI.
- `lo_we`  in  1  `mtlo` write of `A` into LO.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were updated at the previous edge.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE with `start`=1:
  - latch op, sign flags, |A|, |B|. Signed ops take the magnitude; unsigned ops use the value as-is.
  - clear the 64-bit accumulator {P_hi, P_lo}; set the step counter to 31; go to RUN.
- RUN, multiply, each step: if the multiplier LSB is 1, P_hi += multiplicand (33-bit add, carry kept); shift {carry, P_hi, P_lo} right by 1.
- RUN, divide, each step (restoring division):
  - shift {rem, quo} left by 1;
  - trial = rem − divisor (33-bit);
  - if trial is non-negative, rem = trial and the quotient LSB = 1.
- RUN: when the counter reaches 0, go to FIX. Otherwise decrement the counter.
- FIX, sign correction then commit:
  - mult: negate the 64-bit product if sign(A)≠sign(B).
  - div: quotient truncates toward zero. Negate the quotient if the signs differ; the remainder takes the sign of the dividend.
  - multiply: HI = product[63:32], LO = product[31:0].
  - divide: LO = quotient, HI = remainder.
  - go to IDLE.
- Divide by zero (B=0, `div` or `divu`): full sequence length, HI/LO are not modified, `done` still pulses.
- `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (wraps, no trap).
- `hi_we`/`lo_we`:
  - honoured only in IDLE; ignored while busy (stalling is upstream's job).
  - a write in the same IDLE cycle as `start` takes effect; the later commit overwrites it.
- `start` while busy is ignored. The latched operands are never re-sampled mid-operation.
- Reset (any state, including mid-operation): state=IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, counter=0.

## Timing
- Accept edge E0: IDLE and `start`=1.
- `busy`=1 from E0 until E33; RUN occupies edges E1..E32; FIX commits at E33.
- After E33: `busy`=0, `done`=1 for exactly one cycle, new `hi`/`lo` visible.
- Latency is 33 cycles from the accept edge to visible result, identical for all ops.
- Back-to-back: `start` may be asserted in the `done` cycle. It is accepted at that edge, giving a 34-cycle issue interval.
- `hi`/`lo` are registered outputs. `busy` and `done` are decoded from registered state, with no combinational path from inputs.
- `mthi`/`mtlo` at edge E update `hi`/`lo` visibly after E.

## Test plan
- `multu` A=0xFFFFFFFF, B=0xFFFFFFFF:
  - `busy` high 33 cycles, then `done` pulse;
  - HI=0xFFFFFFFE, LO=0x00000001.
- `mult` A=0xFFFFFFFD (−3), B=7: HI=0xFFFFFFFF, LO=0xFFFFFFEB (−21).
- `div` A=0xFFFFFFF9 (−7), B=2: LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
- `divu` A=7, B=0 after `mthi`/`mtlo` of 0x11111111/0x22222222: `done` pulses after 33 cycles; HI/LO unchanged.
- `div` 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- Busy-time requests and reset:
  - start `mult`, pulse `hi_we` with A=0xDEADBEEF at cycle 5 → ignored;
  - second `start` at cycle 6 → ignored;
  - assert `reset` at cycle 10 → next cycle `busy`=0, `done`=0, `hi`=`lo`=0, and a fresh `multu` 3×5 completes 33 cycles after its accept with LO=15, HI=0.
